// File: rtl/lpf_pkg.sv
// Shared types and width helpers for the multi-channel IIR low-pass filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lpf_pkg;

    // Default build parameters. The S1/S2 payload struct is sized from these,
    // so lpf_mc refuses to elaborate if its own parameters disagree.
    localparam int LPF_WIDTH     = 16;
    localparam int LPF_CHANNELS  = 4;
    localparam int LPF_FRAC_W    = 8;
    localparam int LPF_MAX_SHIFT = 7;

    // Accumulator holds y * 2^FRAC_W.
    function automatic int acc_w(input int width, input int frac_w);
        return width + frac_w;
    endfunction

    // $clog2 that never returns zero, so single-entry selects stay one bit wide.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int LPF_ACC_W = acc_w(LPF_WIDTH, LPF_FRAC_W);
    localparam int LPF_CH_W  = clog2_min1(LPF_CHANNELS);
    localparam int LPF_K_W   = clog2_min1(LPF_MAX_SHIFT + 1);

    // S1 carries x << FRAC_W in dat; S2 carries the difference against state.
    // Both fit ACC_W+1 signed bits.
    typedef struct packed {
        logic                        vld;
        logic [LPF_CH_W-1:0]         chan;
        logic [LPF_K_W-1:0]          k;
        logic signed [LPF_ACC_W:0]   dat;
    } pipe_t;

endpackage

// File: rtl/lpf_mc_if.sv
// Sample stream bundle for lpf_mc: input and output valid/ready channels.
// Latency: n/a (wiring only).
// Backpressure: master drives in_* and out_ready; slave drives in_ready and out_*.
interface lpf_mc_if
    import lpf_pkg::*;
#(
    parameter int WIDTH     = LPF_WIDTH,
    parameter int CHANNELS  = LPF_CHANNELS,
    parameter int MAX_SHIFT = LPF_MAX_SHIFT
);
    localparam int CH_W = clog2_min1(CHANNELS);
    localparam int K_W  = clog2_min1(MAX_SHIFT + 1);

    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_chan;
    logic [K_W-1:0]   in_shift;
    logic [WIDTH-1:0] line_in;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_chan;
    logic [WIDTH-1:0] line_out;

    modport master (
        output in_valid, in_chan, in_shift, line_in, out_ready,
        input  in_ready, out_valid, out_chan, line_out
    );

    modport slave (
        input  in_valid, in_chan, in_shift, line_in, out_ready,
        output in_ready, out_valid, out_chan, line_out
    );

endinterface

// File: rtl/lpf_state_ram.sv
// Per-channel filter state: CHANNELS x ACC_W register file, two async read ports, one write port.
// Latency: reads combinational, write lands on the next rising edge.
// Backpressure: none; caller gates we.
// Ports: clk, reset_n (async, active low), clear (sync zero of all entries),
//        we/waddr/wdata (write), raddr_a/rdata_a and raddr_b/rdata_b (reads).
module lpf_state_ram #(
    parameter int N  = 4,
    parameter int DW = 24,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem_q [N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/lpf_mc.sv
// Time-multiplexed first-order IIR low-pass, y += (x - y) >>> k per channel, ACC_W-bit state.
// Latency: out_valid rises on the third rising edge counting the accepting edge; 1 sample/cycle.
// Backpressure: global stall when out_valid && !out_ready; in_ready = !stall && !clear (0 in reset).
// Ports: clk, reset_n (async, active low), clear (sync flush), bus (lpf_mc_if.slave stream).
// Build option: define LPF_ROUND_EN for round-half-up output with positive saturation.
module lpf_mc
    import lpf_pkg::*;
#(
    parameter int WIDTH     = LPF_WIDTH,
    parameter int CHANNELS  = LPF_CHANNELS,
    parameter int FRAC_W    = LPF_FRAC_W,
    parameter int MAX_SHIFT = LPF_MAX_SHIFT
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    clear,
    lpf_mc_if.slave bus
);

    localparam int ACC_W = acc_w(WIDTH, FRAC_W);
    localparam int CH_W  = clog2_min1(CHANNELS);
    localparam int K_W   = clog2_min1(MAX_SHIFT + 1);

    // pipe_t is sized from the package constants.
    if (ACC_W != LPF_ACC_W || CH_W != LPF_CH_W || K_W != LPF_K_W) begin : g_cfg_check
        $error("lpf_mc parameters disagree with lpf_pkg payload widths");
    end

    pipe_t                    s1_q, s1_d, s2_q, s2_d;
    logic                     out_vld_q;
    logic [CH_W-1:0]          out_chan_q;
    logic [WIDTH-1:0]         line_q, line_d;
    logic                     stall, accept, chan_ok, fwd, we;
    logic [K_W-1:0]           k_clamp;
    logic [ACC_W-1:0]         rd_a, rd_b, y_prev;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    rd_b_ext, step;

    assign stall        = out_vld_q && !bus.out_ready;
    assign bus.in_ready = reset_n && !clear && !stall;
    assign accept       = bus.in_valid && bus.in_ready;

    // Out-of-range channels are consumed but never enter the pipeline.
    if ((1 << CH_W) > CHANNELS) begin : g_chan_chk
        assign chan_ok = ({1'b0, bus.in_chan} < (CH_W+1)'(CHANNELS));
    end else begin : g_chan_all
        assign chan_ok = 1'b1;
    end

    if ((1 << K_W) - 1 > MAX_SHIFT) begin : g_k_clamp
        assign k_clamp = (bus.in_shift > K_W'(MAX_SHIFT)) ? K_W'(MAX_SHIFT) : bus.in_shift;
    end else begin : g_k_pass
        assign k_clamp = bus.in_shift;
    end

    always_comb begin
        s1_d      = '0;
        s1_d.vld  = accept && chan_ok;
        s1_d.chan = bus.in_chan;
        s1_d.k    = k_clamp;
        s1_d.dat  = {bus.line_in[WIDTH-1], bus.line_in, {FRAC_W{1'b0}}};
    end

    // S3 arithmetic: the new state for the channel held in S2.
    always_comb begin
        rd_b_ext = {rd_b[ACC_W-1], rd_b};
        step     = $signed(s2_q.dat) >>> s2_q.k;
        acc      = ACC_W'(rd_b_ext + step);
    end

    // The RAM still holds the old value for S2's channel until this edge,
    // so a same-channel sample in S1 takes the freshly computed result.
    assign fwd    = s2_q.vld && (s2_q.chan == s1_q.chan);
    assign y_prev = fwd ? acc : rd_a;

    always_comb begin
        s2_d     = s1_q;
        s2_d.dat = s1_q.dat - {y_prev[ACC_W-1], y_prev};
    end

`ifdef LPF_ROUND_EN
    logic signed [ACC_W:0] rnd;
    logic signed [WIDTH:0] q;
    // Only positive overflow is reachable: rounding can push just past the maximum.
    always_comb begin
        rnd    = {acc[ACC_W-1], acc} + (ACC_W+1)'(2 ** (FRAC_W - 1));
        q      = (WIDTH+1)'(rnd >>> FRAC_W);
        line_d = (!q[WIDTH] && q[WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}} : q[WIDTH-1:0];
    end
`else
    // acc always lies between y[n-1] and x, so the floored value fits WIDTH bits.
    always_comb begin
        line_d = WIDTH'(acc >>> FRAC_W);
    end
`endif

    assign we = !clear && !stall && s2_q.vld;

    lpf_state_ram #(
        .N  (CHANNELS),
        .DW (ACC_W),
        .AW (CH_W)
    ) u_state (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .we      (we),
        .waddr   (s2_q.chan),
        .wdata   (acc),
        .raddr_a (s1_q.chan),
        .rdata_a (rd_a),
        .raddr_b (s2_q.chan),
        .rdata_b (rd_b)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            out_vld_q  <= 1'b0;
            out_chan_q <= '0;
            line_q     <= '0;
        end else if (clear) begin
            s1_q       <= '0;
            s2_q       <= '0;
            out_vld_q  <= 1'b0;
            out_chan_q <= '0;
            line_q     <= '0;
        end else if (!stall) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            out_vld_q <= s2_q.vld;
            if (s2_q.vld) begin
                out_chan_q <= s2_q.chan;
                line_q     <= line_d;
            end
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.line_out  = line_q;

endmodule

// File: tb/tb_lpf_mc.sv
// Self-checking bench for lpf_mc: arithmetic reference model plus directed vectors.
// Latency: n/a.
// Backpressure: exercised by dropping out_ready mid-burst.
module tb_lpf_mc;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int FW = 8;
    localparam int MS = 7;

`ifdef LPF_ROUND_EN
    localparam int NEG2    = -234;
    localparam int SAT_END = 32767;
    localparam int SAT_1ST = 4096;
`else
    localparam int NEG2    = -235;
    localparam int SAT_END = 32766;
    localparam int SAT_1ST = 4095;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic clear;

    always #5 clk = ~clk;

    lpf_mc_if #(.WIDTH(W), .CHANNELS(CH), .MAX_SHIFT(MS)) bus ();

    lpf_mc #(.WIDTH(W), .CHANNELS(CH), .FRAC_W(FW), .MAX_SHIFT(MS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint st [CH];
    int     exp_ch[$], exp_dat[$];
    int     log_ch[$], log_dat[$], log_cyc[$];
    int     last_acc_cyc = 0;
    int     stall_cnt = 0;
    int     mo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: y += floor((x*2^FW - y) / 2^k), output floor(y / 2^FW) or rounded+saturated.
    function automatic int model_step(input int ch, input int k, input int x);
        longint d;
        longint o;
        int     kk;
        kk = (k > MS) ? MS : k;
        d = longint'(x) * (longint'(1) << FW) - st[ch];
        st[ch] = st[ch] + (d >>> kk);
`ifdef LPF_ROUND_EN
        o = (st[ch] + (longint'(1) << (FW - 1))) >>> FW;
        if (o > 32767) o = 32767;
`else
        o = st[ch] >>> FW;
`endif
        return int'(o);
    endfunction

    // Compare process: every output handshake is checked against the model queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            check("reset_out_valid", bus.out_valid, 0);
            check("reset_in_ready", bus.in_ready, 0);
            exp_ch.delete();
            exp_dat.delete();
            for (int i = 0; i < CH; i++) st[i] = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_dat.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got chan %0d data %0d, want no output",
                             bus.out_chan, $signed(bus.line_out));
                end else begin
                    check("out_chan", bus.out_chan, exp_ch[0]);
                    check("line_out", $signed(bus.line_out), exp_dat[0]);
                    void'(exp_ch.pop_front());
                    void'(exp_dat.pop_front());
                end
                log_ch.push_back(int'(bus.out_chan));
                log_dat.push_back(int'($signed(bus.line_out)));
                log_cyc.push_back(cyc);
            end
            if (!bus.in_ready && !clear) stall_cnt++;
            if (clear) begin
                exp_ch.delete();
                exp_dat.delete();
                for (int i = 0; i < CH; i++) st[i] = 0;
            end else if (bus.in_valid && bus.in_ready) begin
                mo = model_step(int'(bus.in_chan), int'(bus.in_shift), int'($signed(bus.line_in)));
                if (int'(bus.in_chan) < CH) begin
                    exp_ch.push_back(int'(bus.in_chan));
                    exp_dat.push_back(mo);
                end
                last_acc_cyc = cyc;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int ch, input int k, input int x);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_chan  = 2'(ch);
        bus.in_shift = 3'(k);
        bus.line_in  = 16'(x);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want acceptance", n);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_dat.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_pending"}, exp_dat.size(), 0);
    endtask

    task automatic check_log(input string name, input int idx, input int ch, input int val);
        check({name, "_chan"}, (idx < log_ch.size()) ? log_ch[idx] : -1, ch);
        check({name, "_data"}, (idx < log_dat.size()) ? log_dat[idx] : 99999, val);
    endtask

    int base;
    int t0;
    int stall0;

    initial begin
        reset_n      = 1'b0;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_chan  = '0;
        bus.in_shift = '0;
        bus.line_in  = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_chan", bus.out_chan, 0);
        check("rst_line_out", bus.line_out, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Step response, back-to-back (forwarding path).
        base = log_dat.size();
        send(0, 3, 1000);
        t0 = last_acc_cyc;
        send(0, 3, 1000);
        send(0, 3, 1000);
        drain("step");
        check("latency", (base < log_cyc.size()) ? log_cyc[base] - t0 : -1, 3);
        check_log("step0", base,     0, 125);
        check_log("step1", base + 1, 0, 234);
        check_log("step2", base + 2, 0, 330);

        // Same inputs widely spaced.
        pulse_clear();
        base = log_dat.size();
        for (int i = 0; i < 3; i++) begin
            send(0, 3, 1000);
            idle(10);
        end
        drain("spaced");
        check_log("spaced0", base,     0, 125);
        check_log("spaced1", base + 1, 0, 234);
        check_log("spaced2", base + 2, 0, 330);

        // Negative step on ch1.
        pulse_clear();
        base = log_dat.size();
        send(1, 3, -1000);
        send(1, 3, -1000);
        drain("neg");
        check_log("neg0", base,     1, -125);
        check_log("neg1", base + 1, 1, NEG2);

        // Channel independence.
        pulse_clear();
        base = log_dat.size();
        send(0, 3, 1000);
        send(2, 3, -1000);
        send(0, 3, 1000);
        send(2, 3, -1000);
        drain("ilv");
        check_log("ilv0", base,     0, 125);
        check_log("ilv1", base + 1, 2, -125);
        check_log("ilv2", base + 2, 0, 234);
        check_log("ilv3", base + 3, 2, NEG2);

        // k = 0 passthrough at the limits.
        base = log_dat.size();
        send(3, 0, 32767);
        send(3, 0, -32768);
        drain("k0");
        check_log("k0_max", base,     3, 32767);
        check_log("k0_min", base + 1, 3, -32768);

        // Long run at full scale.
        pulse_clear();
        base = log_dat.size();
        for (int i = 0; i < 200; i++) send(0, 3, 32767);
        drain("sat");
        check("sat_count", log_dat.size() - base, 200);
        check_log("sat_first", base, 0, SAT_1ST);
        check_log("sat_last", base + 199, 0, SAT_END);

        // Backpressure in a 10-sample burst.
        pulse_clear();
        base = log_dat.size();
        stall0 = stall_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) send(i % 4, 2, i * 1000 - 3000);
            end
            begin
                idle(3);
                bus.out_ready = 1'b0;
                idle(5);
                bus.out_ready = 1'b1;
            end
        join
        drain("bp");
        check("bp_in_ready_dropped", (stall_cnt - stall0) > 0, 1);
        check("bp_count", log_dat.size() - base, 10);
        for (int i = 0; i < 10; i++)
            check("bp_order", (base + i < log_ch.size()) ? log_ch[base + i] : -1, i % 4);

        // Clear with samples in flight.
        pulse_clear();
        send(0, 3, 5000);
        send(0, 3, 5000);
        send(0, 3, 5000);
        pulse_clear();
        base = log_dat.size();
        idle(5);
        check("clear_dropped", log_dat.size() - base, 0);
        send(0, 3, 1000);
        drain("clr");
        check("clr_count", log_dat.size() - base, 1);
        check_log("clr_first", base, 0, 125);

        // Asynchronous reset mid-burst.
        send(1, 2, 700);
        send(1, 2, 700);
        send(1, 2, 700);
        send(1, 2, 700);
        #2;
        check("pre_reset_out_valid", bus.out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_in_ready", bus.in_ready, 0);
        idle(2);
        reset_n = 1'b1;
        base = log_dat.size();
        send(0, 3, 1000);
        drain("post_rst");
        check("post_rst_count", log_dat.size() - base, 1);
        check_log("post_rst", base, 0, 125);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpf_mc.md
# lpf_mc

Multi-channel, time-multiplexed first-order IIR low-pass filter with a runtime-selectable coefficient, fractional guard bits and a valid/ready stream interface. It replaces the single-channel fixed-alpha LPF in the audio front end. It sits between the ADC deserialiser (interleaved channels) and the feature-extraction path, removing hiss and HF noise per channel. It computes y[n] = y[n-1] + (x[n] − y[n-1]) >>> k independently for each channel.

## Interface
- WIDTH, 16: sample width, signed two's complement.
- CHANNELS, 4: number of interleaved channels, ≥1.
- FRAC_W, 8: fractional guard bits kept in per-channel state, ≥1.
- MAX_SHIFT, 7: largest legal coefficient shift k (alpha = 2^-k).
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous pulse: zero all channel state, drop in-flight samples.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_chan  in  $clog2(CHANNELS) (min 1)  channel index of input sample.
- in_shift  in  $clog2(MAX_SHIFT+1)  coefficient k for this sample.
- line_in  in  WIDTH  signed input sample.
- out_valid  out  1  filtered sample present.
- out_ready  in  1  downstream accepts output.
- out_chan  out  $clog2(CHANNELS) (min 1)  channel of line_out.
- line_out  out  WIDTH  signed filtered sample.

## Operation
- Reset values: in_ready=0 while reset_n low, then 1; out_valid=0; out_chan=0; line_out=0; all channel state 0; all pipeline valid bits 0.
- Transfer on in_valid && in_ready; output handshake on out_valid && out_ready.
- State per channel: ACC_W = WIDTH+FRAC_W signed accumulator, representing y·2^FRAC_W.
- Pipeline:
  - S1: registers sample, channel and k.
  - S2: registers diff = (x<<FRAC_W) − state[chan], ACC_W+1 bits, no overflow possible.
  - S3: acc = state + (diff >>> k), arithmetic shift; writes state[chan]; loads output registers.
- k = 0: acc = x<<FRAC_W, so the output equals the input exactly. in_shift > MAX_SHIFT is clamped to MAX_SHIFT.
- Output conversion: line_out = acc >>> FRAC_W (floor). The result is always within [y[n-1], x], so truncation cannot overflow.
- Hazard: when S2 and S3 hold the same channel, S2 reads the S3 result, not the stale array entry. Back-to-back same-channel samples must give results identical to widely spaced ones.
- Backpressure: the pipeline is a single global-stall shift register. stall = out_valid && !out_ready, and in_ready = !stall. Bubbles advance and collapse; no sample is dropped or duplicated.
- clear:
  - Zeroes all state and all pipeline valid bits on the next edge, including the output register.
  - A sample offered in the same cycle is not accepted: in_ready=0 during clear.
  - clear overrides stall.
- Out-of-range in_chan (≥CHANNELS) is accepted and discarded. No state is written and no output is produced.

## Timing
- Latency: 3 cycles from accepting edge to out_valid, with no stall.
- Throughput: 1 sample/cycle, any channel order.
- in_ready depends combinationally on out_ready (one level).
- Asynchronous reset mid-stream: everything returns to reset values immediately. First acceptance is on the first edge after deassertion.

## Configuration
- LPF_ROUND_EN defined: the output uses round-half-up, line_out = (acc + 2^(FRAC_W−1)) >>> FRAC_W, saturated to the WIDTH maximum on positive overflow. State is unaffected.
- LPF_ROUND_EN undefined: floor truncation as above, and no saturation logic.

## Structure
- Package lpf_pkg holds:
  - the ACC_W derivation function;
  - the clog2-min-1 helper for channel width;
  - a typedef for the S1/S2 pipeline payload struct (valid, chan, k, data).
- One sub-module, lpf_state_ram: CHANNELS×ACC_W register file with a clear input.
  - Asynchronous read, synchronous write, async reset to zero.
  - Forwarding logic stays in lpf_mc.

## Test plan
All cases use WIDTH=16, FRAC_W=8, CHANNELS=4.
- Step response: ch0, k=3, inputs 1000, 1000, 1000 back-to-back -> outputs 125, 234, 330 on ch0, arriving 3 cycles after each input.
- Same inputs spaced 10 cycles apart -> identical 125, 234, 330. This verifies forwarding.
- Negative step: ch1, k=3, inputs −1000, −1000 -> −125 then −235 without LPF_ROUND_EN; −125 then −234 with it.
- Channel independence: interleave ch0=1000 and ch2=−1000, k=3, four samples -> ch0: 125, 234; ch2: −125, −235 (truncating build).
- k=0 passthrough plus limits: inputs 32767 then −32768 on ch3 -> the same values out. With LPF_ROUND_EN and k=3 held at 32767 for 200 samples, the output never exceeds 32767.
- Backpressure, clear and reset:
  - out_ready low for 5 cycles during a 10-sample burst -> in_ready drops; all 10 outputs appear in order with none lost.
  - clear mid-burst -> in-flight samples are dropped and the next ch0 sample of 1000 at k=3 outputs 125.
  - reset_n low mid-burst -> out_valid=0 immediately.
